ysyx_25030081_lsu: RTL and testbench
====================================

// Module: ysyx_25030081_lsu
// PURPOSE
//   Load/store unit: executes the memory request the decoder emits (mem_ren/mem_wen/mem_op)
//   on the data-side SimpleBus. Sits between EXU (upstream) and WBU (downstream).
//   Generates byte strobes and lane-aligned write data, waits for the bus, then
//   sign/zero-extends load data. Serializes one access at a time; stalls the core via ready.
// PARAMETERS
//   RESET_PC_UNUSED  -- none beyond:  XLEN  32  data/address width (only 32 supported)
// PORTS
//   clk          in   1     core clock
//   rst          in   1     synchronous, active-high reset
//   in_valid     in   1     EXU has an access (or pass-through) for this instruction
//   in_ready     out  1     LSU can accept; high only in IDLE
//   in_ren       in   1     load (decoder mem_ren)
//   in_wen       in   1     store (decoder mem_wen)
//   in_op        in   3     [2]=unsigned load, [1]=word, [0]=half; [1:0]=00 -> byte
//   in_addr      in   32    effective address (ALU result)
//   in_wdata     in   32    store data (rs2), LSB-justified
//   out_valid    out  1     result for WBU valid; held until out_ready
//   out_ready    in   1     WBU accepts result
//   out_rdata    out  32    extended load data; 0 for stores/pass-through
//   out_err      out  1     misaligned address or bus error
//   req_valid    out  1     bus request valid
//   req_ready    in   1     bus accepts request
//   req_wen      out  1     1=write, 0=read
//   req_addr     out  32    word-aligned address {in_addr[31:2],2'b00}
//   req_wdata    out  32    lane-shifted write data
//   req_wstrb    out  4     byte strobes (0 for reads)
//   rsp_valid    in   1     bus response valid
//   rsp_ready    out  1     LSU accepts response; high only in RSP
//   rsp_rdata    in   32    read data, full word
//   rsp_err      in   1     bus error
// BEHAVIOUR
//   - Reset: state=IDLE; out_valid, out_err, req_valid, rsp_ready=0; out_rdata, req_* = 0.
//     Reset mid-access abandons it: req_valid/rsp_ready low the next cycle, no result emitted.
//   - FSM: IDLE -(in_valid & (ren|wen) & aligned)-> REQ -(req_ready)-> RSP -(rsp_valid)-> DONE
//          -(out_ready)-> IDLE. in_valid with neither ren nor wen, or misaligned -> DONE directly.
//   - Inputs latched on in_valid&in_ready; wen has priority if ren&wen both set.
//   - Alignment: half needs addr[0]=0, word needs addr[1:0]=0; violation -> out_err=1, no bus access.
//   - REQ: req_valid=1, all req_* stable until req_ready (AXI-style; no retraction).
//   - Strobes: byte 4'b0001<<a, half 4'b0011<<a, word 4'b1111 (a=addr[1:0]);
//     req_wdata = in_wdata << 8*a.
//   - Load: d = rsp_rdata >> 8*a; byte -> {{24{~u&d[7]}},d[7:0]}, half -> {{16{~u&d[15]}},d[15:0]},
//     word -> d. Latched on rsp_valid&rsp_ready together with out_err=rsp_err.
//   - rsp_valid seen while not in RSP is ignored. Response in same cycle as req_ready is not
//     accepted (RSP entered next cycle; bus must hold rsp_valid).
//   - Latency: bus access >= 3 cycles accept->out_valid (IDLE,REQ,RSP); pass-through/misaligned 1.
//   - DONE: out_valid=1 held with stable out_rdata/out_err until out_ready; in_ready=0.
// STRUCTURE
//   - Shared defines header: mem_op field encodings, FSM state codes (IDLE/REQ/RSP/DONE, 2 bits).
//   - One sub-module: ysyx_25030081_lsu_align (combinational: strobe/wdata shift, load extract/extend).
// TESTING
//   - lb @0x8000_0003, rsp_rdata=0x80FF_1234 -> req_addr 0x8000_0000, wstrb 0, out_rdata 0xFFFF_FF80.
//   - lhu @0x8000_0002, rsp_rdata=0x9ABC_0000 -> out_rdata 0x0000_9ABC, out_err 0.
//   - sb wdata=0x0000_00A5 @0x8000_0001 -> req_wdata 0x0000_A500, wstrb 4'b0010, out_rdata 0.
//   - lw @0x8000_0002 -> no req_valid, out_valid next cycle with out_err=1.
//   - req_ready low 3 cycles, out_ready low 2 cycles -> req_* and out_* stable, in_ready=0 throughout.
//   - rst asserted while in RSP -> next cycle IDLE, rsp_ready=0, no out_valid; rsp_err=1 case -> out_err=1.

Source files
------------

// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared definitions for the load/store unit:
// mem_op field positions, FSM state codes, alignment helper.
package ysyx_25030081_lsu_pkg;

   localparam int OP_UNS  = 2;
   localparam int OP_WORD = 1;
   localparam int OP_HALF = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // word needs a[1:0]==0, half needs a[0]==0, byte always fine
   function automatic logic misaligned(
      input logic [2:0] op,
      input logic [1:0] a
   );
      return (op[OP_WORD] && (a != 2'b00))
          || (!op[OP_WORD] && op[OP_HALF] && a[0]);
   endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Lane steering for the LSU: store strobes / data shift
// and load byte extraction with sign or zero extension.
module ysyx_25030081_lsu_align (
   input  logic [2:0]  st_op,
   input  logic [1:0]  st_a,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata_sh,
   input  logic [2:0]  ld_op,
   input  logic [1:0]  ld_a,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);
   import ysyx_25030081_lsu_pkg::*;

   logic [31:0] d;
   logic        sx;

   // store side: shift data into its byte lane, strobe the lanes touched
   always_comb begin
      st_wdata_sh = st_wdata << {st_a, 3'b000};
      st_wstrb    = 4'b0001 << st_a;
      unique case (1'b1)
         st_op[OP_WORD]:                    st_wstrb = 4'b1111;
         (!st_op[OP_WORD] && st_op[OP_HALF]): st_wstrb = 4'b0011 << st_a;
         default:                           st_wstrb = 4'b0001 << st_a;
      endcase
   end

   // load side: bring addressed lane down to bit 0, then extend
   always_comb begin
      d       = ld_rdata >> {ld_a, 3'b000};
      sx      = ~ld_op[OP_UNS];
      ld_data = {{24{sx & d[7]}}, d[7:0]};
      unique case (1'b1)
         ld_op[OP_WORD]:                    ld_data = d;
         (!ld_op[OP_WORD] && ld_op[OP_HALF]): ld_data = {{16{sx & d[15]}}, d[15:0]};
         default:                           ld_data = {{24{sx & d[7]}}, d[7:0]};
      endcase
   end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: one SimpleBus access at a time between EXU and WBU,
// stalling the core through in_ready until the result is taken.
module ysyx_25030081_lsu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_ren,
   input  logic            in_wen,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rdata,
   output logic            out_err,
   output logic            req_valid,
   input  logic            req_ready,
   output logic            req_wen,
   output logic [XLEN-1:0] req_addr,
   output logic [XLEN-1:0] req_wdata,
   output logic [3:0]      req_wstrb,
   input  logic            rsp_valid,
   output logic            rsp_ready,
   input  logic [XLEN-1:0] rsp_rdata,
   input  logic            rsp_err
);
   import ysyx_25030081_lsu_pkg::*;

   lsu_state_e  state;
   logic [2:0]  op_q;
   logic [1:0]  a_q;
   logic        access;
   logic        mis;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata_sh;
   logic [31:0] ld_data;

   assign access   = in_ren | in_wen;
   assign mis      = access & misaligned(in_op, in_addr[1:0]);
   assign in_ready = (state == ST_IDLE);

   ysyx_25030081_lsu_align u_align (
      .st_op       (in_op),
      .st_a        (in_addr[1:0]),
      .st_wdata    (in_wdata),
      .st_wstrb    (st_wstrb),
      .st_wdata_sh (st_wdata_sh),
      .ld_op       (op_q),
      .ld_a        (a_q),
      .ld_rdata    (rsp_rdata),
      .ld_data     (ld_data)
   );

   // access sequencer with registered bus and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         out_valid <= 1'b0;
         out_rdata <= '0;
         out_err   <= 1'b0;
         req_valid <= 1'b0;
         req_wen   <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= '0;
         rsp_ready <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: if (in_valid) begin
               op_q      <= in_op;
               a_q       <= in_addr[1:0];
               out_rdata <= '0;
               out_err   <= mis;
               if (access && !mis) begin
                  state     <= ST_REQ;
                  req_valid <= 1'b1;
                  req_wen   <= in_wen;
                  req_addr  <= {in_addr[XLEN-1:2], 2'b00};
                  req_wdata <= in_wen ? st_wdata_sh : '0;
                  req_wstrb <= in_wen ? st_wstrb : 4'b0000;
               end else begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_REQ: if (req_ready) begin
               req_valid <= 1'b0;
               rsp_ready <= 1'b1;
               state     <= ST_RSP;
            end
            ST_RSP: if (rsp_valid) begin
               rsp_ready <= 1'b0;
               out_valid <= 1'b1;
               out_err   <= rsp_err;
               out_rdata <= req_wen ? '0 : ld_data;
               state     <= ST_DONE;
            end
            ST_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Bench for the LSU: directed accesses, a size/lane model of
// expected bus and result values, and a per-cycle compare process.
module tb_ysyx_25030081_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_ren = 1'b0;
   logic        in_wen = 1'b0;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_addr = 32'd0;
   logic [31:0] in_wdata = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rdata;
   logic        out_err;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid = 1'b0;
   logic        rsp_ready;
   logic [31:0] rsp_rdata = 32'd0;
   logic        rsp_err = 1'b0;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   bit in_flight = 1'b0;

   logic        exp_bus, exp_wen, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_strb;

   logic        prev_rv = 1'b0, prev_rr = 1'b0;
   logic        prev_ov = 1'b0, prev_or = 1'b0;
   logic [69:0] prev_req = '0;

   ysyx_25030081_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ren(in_ren), .in_wen(in_wen), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_err(out_err),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   // expected behaviour from access size and byte offset, plain arithmetic
   task automatic model(input bit ren, input bit wen, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input bit berr);
      int sz, a;
      bit acc, mis;
      longint v, m;
      sz  = op[1] ? 4 : (op[0] ? 2 : 1);
      a   = int'(addr % 32'd4);
      acc = ren | wen;
      mis = acc && ((a % sz) != 0);
      exp_bus   = acc && !mis;
      exp_wen   = wen;
      exp_addr  = addr - 32'(a);
      exp_strb  = wen ? 4'(((1 << sz) - 1) << a) : 4'd0;
      exp_wdata = wen ? 32'(longint'(wdata) << (8 * a)) : 32'd0;
      exp_rdata = 32'd0;
      if (exp_bus && !wen) begin
         m = (64'sd1 <<< (8 * sz)) - 1;
         v = (longint'(rdata) >> (8 * a)) & m;
         if (!op[2] && v >= (m + 1) / 2) v = v - (m + 1);
         exp_rdata = 32'(v);
      end
      exp_err = mis || (exp_bus && berr);
   endtask

   // per-cycle compare of DUT against the model expectations
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", in_ready, !in_flight);
         if (req_valid) begin
            check("unexpected req", req_valid, exp_bus);
            check("req_wen", req_wen, exp_wen);
            check("req_addr", req_addr, exp_addr);
            check("req_wstrb", req_wstrb, exp_strb);
            if (exp_wen) check("req_wdata", req_wdata, exp_wdata);
         end
         if (prev_rv && !prev_rr)
            check("req hold", {req_valid, req_wen, req_addr, req_wdata, req_wstrb},
                  {1'b1, prev_req[68:0]});
         if (out_valid) begin
            check("out_rdata", out_rdata, exp_rdata);
            check("out_err", out_err, exp_err);
         end
         if (prev_ov && !prev_or) check("out hold", out_valid, 1'b1);
      end
      prev_rv  = req_valid;
      prev_rr  = req_ready;
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_req = {req_valid, req_wen, req_addr, req_wdata, req_wstrb};
   end

   task automatic txn(input string nm, input bit ren_i, input bit wen_i,
                      input logic [2:0] op_i, input logic [31:0] addr_i,
                      input logic [31:0] wdata_i, input logic [31:0] rdata_i,
                      input bit err_i, input int rql, input int rsl, input int orl,
                      input logic [31:0] l_addr, input logic [3:0] l_strb,
                      input logic [31:0] l_wdata, input logic [31:0] l_rdata,
                      input bit l_err);
      int c0, k, exp_lat;
      model(ren_i, wen_i, op_i, addr_i, wdata_i, rdata_i, err_i);
      exp_lat = exp_bus ? 3 + rql + rsl : 1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_ren = ren_i; in_wen = wen_i;
      in_op = op_i; in_addr = addr_i; in_wdata = wdata_i;
      c0 = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_wdata = 32'd0;
      in_flight = 1'b1;
      if (exp_bus) begin
         check({nm, " req_valid"}, req_valid, 1'b1);
         check({nm, " req_addr"}, req_addr, l_addr);
         check({nm, " req_wstrb"}, req_wstrb, l_strb);
         if (wen_i) check({nm, " req_wdata"}, req_wdata, l_wdata);
         repeat (rql) begin @(posedge clk); #1; end
         req_ready = 1'b1;
         if (rsl == 0) begin
            rsp_valid = 1'b1; rsp_rdata = rdata_i; rsp_err = err_i;
         end
         @(posedge clk); #1;
         req_ready = 1'b0;
         check({nm, " rsp_ready"}, rsp_ready, 1'b1);
         check({nm, " rsp not early"}, out_valid, 1'b0);
         if (rsl > 0) begin
            repeat (rsl) begin @(posedge clk); #1; end
            rsp_valid = 1'b1; rsp_rdata = rdata_i; rsp_err = err_i;
         end
         @(posedge clk); #1;
         rsp_valid = 1'b0; rsp_rdata = 32'd0; rsp_err = 1'b0;
      end else begin
         check({nm, " no req"}, req_valid, 1'b0);
      end
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      check({nm, " out_valid"}, out_valid, 1'b1);
      check({nm, " latency"}, cyc - c0, exp_lat);
      repeat (orl) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      check({nm, " rdata"}, out_rdata, l_rdata);
      check({nm, " err"}, out_err, l_err);
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_flight = 1'b0;
      check({nm, " out drop"}, out_valid, 1'b0);
   endtask

   initial begin
      exp_bus = 0; exp_wen = 0; exp_err = 0;
      exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_strb = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", out_valid, 1'b0);
      check("rst out_err", out_err, 1'b0);
      check("rst req_valid", req_valid, 1'b0);
      check("rst rsp_ready", rsp_ready, 1'b0);
      check("rst out_rdata", out_rdata, 32'd0);
      check("rst req_bus", {req_wen, req_addr, req_wdata, req_wstrb}, 69'd0);
      rst = 1'b0;
      check("rst in_ready", in_ready, 1'b1);

      txn("lb", 1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1, 0,
          32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80, 0);
      txn("lhu", 1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h9ABC_0000, 0, 0, 1, 0,
          32'h8000_0000, 4'h0, 32'h0, 32'h0000_9ABC, 0);
      txn("sb", 0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 0, 1, 0,
          32'h8000_0000, 4'b0010, 32'h0000_A500, 32'h0, 0);
      txn("lw mis", 1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 0,
          32'h0, 4'h0, 32'h0, 32'h0, 1);
      txn("sw stall", 0, 1, 3'b010, 32'h8000_0010, 32'h1234_5678, 32'h0, 0, 3, 0, 2,
          32'h8000_0010, 4'hF, 32'h1234_5678, 32'h0, 0);
      txn("lh", 1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_7777, 0, 0, 0, 0,
          32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_8001, 0);
      txn("lhu mis", 1, 0, 3'b101, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 1,
          32'h0, 4'h0, 32'h0, 32'h0, 1);
      txn("pass", 0, 0, 3'b010, 32'h8000_0003, 32'h0, 32'h0, 0, 0, 0, 0,
          32'h0, 4'h0, 32'h0, 32'h0, 0);
      txn("lw err", 1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 1, 1, 2, 0,
          32'h8000_0004, 4'h0, 32'h0, 32'hCAFE_F00D, 1);
      txn("sh", 0, 1, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 32'h0, 0, 0, 1, 0,
          32'h8000_0004, 4'b1100, 32'hBEEF_0000, 32'h0, 0);
      txn("lbu", 1, 0, 3'b100, 32'h8000_0002, 32'h0, 32'h00AB_0000, 0, 1, 2, 1,
          32'h8000_0000, 4'h0, 32'h0, 32'h0000_00AB, 0);
      txn("ren+wen", 1, 1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'h5555_5555, 0, 0, 1, 0,
          32'h8000_0008, 4'hF, 32'h1122_3344, 32'h0, 0);
      txn("sb hi", 0, 1, 3'b000, 32'h8000_0003, 32'hFFFF_FF5A, 32'h0, 0, 0, 1, 0,
          32'h8000_0000, 4'b1000, 32'h5A00_0000, 32'h0, 0);
      txn("lb pos", 1, 0, 3'b000, 32'h8000_0000, 32'h0, 32'h0000_007F, 0, 0, 1, 0,
          32'h8000_0000, 4'h0, 32'h0, 32'h0000_007F, 0);

      // abandon an access while waiting for the response
      model(1, 0, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_ren = 1'b1; in_op = 3'b000; in_addr = 32'h8000_0000;
      @(posedge clk); #1;
      in_valid = 1'b0; in_ren = 1'b0; in_flight = 1'b1;
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
      check("rstmid rsp_ready before", rsp_ready, 1'b1);
      rst = 1'b1;
      rsp_valid = 1'b1; rsp_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      rst = 1'b0; in_flight = 1'b0;
      check("rstmid rsp_ready", rsp_ready, 1'b0);
      check("rstmid out_valid", out_valid, 1'b0);
      check("rstmid in_ready", in_ready, 1'b1);
      check("rstmid req_valid", req_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rstmid no result", out_valid, 1'b0);
      rsp_valid = 1'b0; rsp_rdata = 32'd0;

      txn("lbu after rst", 1, 0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_C300, 0, 0, 1, 0,
          32'h8000_0000, 4'h0, 32'h0, 32'h0000_00C3, 0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
